// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped cache tag path.
package cache;

  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 4;

  // Request to the tag memory: entry index and write enable.
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_req_t;

  // One tag entry as stored in the tag memory.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_t;

endpackage

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag controller. It clears every tag entry after reset,
// then serves one CPU lookup at a time. A miss writes back a dirty victim
// (if there is one), refills the line, and updates the tag entry.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once mem_req_valid is raised, it stays high with
// mem_req_wb/mem_req_addr unchanged until that edge. req_ready does not
// depend on req_valid. mem_resp_valid is a single-cycle completion pulse and
// is only sampled in the WAIT states.
module cache_tag_ctrl
  import cache::*;
#(
  parameter int size = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wb,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  output cache_req_t  tag_req,
  output cache_tag_t  tag_write,
  input  cache_tag_t  tag_read
);

  localparam int CNT_W = $clog2(size);

  typedef enum logic [2:0] {
    INIT, IDLE, COMPARE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, UPDATE
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [TAG_W-1:0]   victim_tag;
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;
  logic               hit;

  assign r_tag   = r_addr[31:14];
  assign r_index = r_addr[13:4];
  assign hit     = tag_read.valid && (tag_read.tag == r_tag);

  // State register; reset restarts the invalidation sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // Sweep counter; it stops at the last entry, so the sweep ends without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == INIT && cnt != CNT_W'(size - 1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Capture the accepted request, and the victim tag when a lookup misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      victim_tag <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_addr <= req_addr;
        r_we   <= req_we;
      end
      if (state == COMPARE && !hit) victim_tag <= tag_read.tag;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wb    = 1'b0;
    mem_req_addr  = '0;
    tag_req.index = r_index;
    tag_req.we    = 1'b0;
    tag_write     = '0;
    case (state)
      INIT: begin
        tag_req.index = INDEX_W'(cnt);
        tag_req.we    = 1'b1;
        if (cnt == CNT_W'(size - 1)) state_nx = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          // A store to a clean line marks it dirty; a dirty line needs no write.
          if (r_we && !tag_read.dirty) begin
            tag_req.we = 1'b1;
            tag_write  = '{valid: 1'b1, dirty: 1'b1, tag: r_tag};
          end
          state_nx = IDLE;
        end else if (tag_read.valid && tag_read.dirty) begin
          state_nx = WB_REQ;
        end else begin
          state_nx = RF_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wb    = 1'b1;
        mem_req_addr  = {victim_tag, r_index, 4'h0};
        if (mem_req_ready) state_nx = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_resp_valid) state_nx = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr[31:4], 4'h0};
        if (mem_req_ready) state_nx = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_resp_valid) state_nx = UPDATE;
      end
      UPDATE: begin
        tag_req.we = 1'b1;
        tag_write  = '{valid: 1'b1, dirty: r_we, tag: r_tag};
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: tag memory model, memory responder tasks,
// a reference tag model and scoreboard queues for memory requests and responses.
module tb_cache_tag_ctrl;
  import cache::*;

  localparam int SIZE = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic        resp_valid;
  logic        resp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wb;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  cache_req_t  tag_req;
  cache_tag_t  tag_write;
  cache_tag_t  tag_read;

  cache_tag_ctrl #(.size(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wb(mem_req_wb), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read)
  );

  // Tag memory: synchronous write, combinational read.
  cache_tag_t tag_mem [SIZE];
  always @(posedge clk) if (tag_req.we) tag_mem[tag_req.index] <= tag_write;
  assign tag_read = tag_mem[tag_req.index];

  // ---------------- scoreboard ----------------
  logic [32:0] exp_mem_q[$];
  logic [0:0]  exp_resp_q[$];
  logic [32:0] mem_log[$];
  int n_checks = 0;
  int n_fail = 0;
  int resp_count = 0;
  logic [INDEX_W-1:0] last_wr_index;
  cache_tag_t         last_wr_data;

  // Reference tag state.
  logic             mdl_valid [SIZE];
  logic             mdl_dirty [SIZE];
  logic [TAG_W-1:0] mdl_tag   [SIZE];

  // Monitor: compares memory handshakes and responses against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (tag_req.we) begin
        last_wr_index = tag_req.index;
        last_wr_data  = tag_write;
      end
      if (mem_req_valid && mem_req_ready) begin
        logic [32:0] e;
        mem_log.push_back({mem_req_wb, mem_req_addr});
        n_checks++;
        if (exp_mem_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_req_unexpected: got wb=%0b addr=%h, expected none", mem_req_wb, mem_req_addr);
        end else begin
          e = exp_mem_q.pop_front();
          if ({mem_req_wb, mem_req_addr} !== e) begin
            n_fail++;
            $display("FAIL mem_req: got wb=%0b addr=%h, expected wb=%0b addr=%h",
                     mem_req_wb, mem_req_addr, e[32], e[31:0]);
          end
        end
      end
      if (resp_valid) begin
        logic [0:0] h;
        resp_count++;
        n_checks++;
        if (exp_resp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got hit=%0b, expected no response", resp_hit);
        end else begin
          h = exp_resp_q.pop_front();
          if (resp_hit !== h) begin
            n_fail++;
            $display("FAIL resp_hit: got %0b, expected %0b", resp_hit, h);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < SIZE; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_dirty[i] = 1'b0;
      mdl_tag[i]   = '0;
    end
  endtask

  // Predict the outcome from the model, queue expectations, and present the
  // request for one cycle. Returns in the cycle after acceptance.
  task automatic issue(input logic [31:0] addr, input logic we, output int n_mem);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic               h;
    idx = addr[13:4];
    tg  = addr[31:14];
    h   = mdl_valid[idx] && (mdl_tag[idx] == tg);
    n_mem = 0;
    if (h) begin
      if (we) mdl_dirty[idx] = 1'b1;
    end else begin
      if (mdl_valid[idx] && mdl_dirty[idx]) begin
        exp_mem_q.push_back({1'b1, mdl_tag[idx], idx, 4'h0});
        n_mem++;
      end
      exp_mem_q.push_back({1'b0, addr[31:4], 4'h0});
      n_mem++;
      mdl_valid[idx] = 1'b1;
      mdl_dirty[idx] = we;
      mdl_tag[idx]   = tg;
    end
    exp_resp_q.push_back(h);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle: got %0b, expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Behavioural memory side for one request.
  task automatic serve_mem(input int ready_delay, input int resp_delay, input bit early, input bit respond);
    int k;
    logic [32:0] seen;
    k = 0;
    @(negedge clk);
    while (mem_req_valid !== 1'b1 && k < 100) begin
      tick();
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_req_timeout: got valid=%0b, expected 1 within 100 cycles", mem_req_valid);
      tick();
      return;
    end
    seen = {mem_req_wb, mem_req_addr};
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({mem_req_valid, mem_req_wb, mem_req_addr} !== {1'b1, seen}) begin
        n_fail++;
        $display("FAIL mem_req_stable: got v=%0b wb=%0b addr=%h, expected v=1 wb=%0b addr=%h",
                 mem_req_valid, mem_req_wb, mem_req_addr, seen[32], seen[31:0]);
      end
    end
    tick();
    mem_req_ready = 1'b1;
    if (early) mem_resp_valid = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_quiet: got mem_req_valid=%0b resp_valid=%0b, expected 0 0", mem_req_valid, resp_valid);
    end
    tick();
    if (!respond) return;
    repeat (resp_delay) tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    int k;
    k = 0;
    while (resp_count == start && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (resp_count == start) begin
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid, expected one within 100 cycles");
    end
    tick();
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input int ready_delay);
    int start, n_mem;
    start = resp_count;
    issue(addr, we, n_mem);
    for (int i = 0; i < n_mem; i++) serve_mem((i == n_mem - 1) ? ready_delay : 0, 1, 1'b0, 1'b1);
    wait_resp(start);
  endtask

  task automatic check_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (tag_req.we !== 1'b1 || tag_req.index !== INDEX_W'(i) || req_ready !== 1'b0 || tag_write !== '0) begin
        n_fail++;
        $display("FAIL sweep[%0d]: got we=%0b index=%h ready=%0b data=%h, expected we=1 index=%h ready=0 data=0",
                 i, tag_req.we, tag_req.index, req_ready, tag_write, INDEX_W'(i));
      end
      tick();
    end
  endtask

  task automatic check_last_write(input logic [INDEX_W-1:0] idx, input cache_tag_t d, input string name);
    n_checks++;
    if (last_wr_index !== idx || last_wr_data !== d) begin
      n_fail++;
      $display("FAIL %s: got index=%h data=%h, expected index=%h data=%h", name, last_wr_index, last_wr_data, idx, d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wb} !== 5'b0 || mem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%0b rv=%0b hit=%0b mv=%0b wb=%0b addr=%h, expected all 0",
               req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wb, mem_req_addr);
    end
    n_checks++;
    if (tag_req !== {10'h0, 1'b1} || tag_write !== '0) begin
      n_fail++;
      $display("FAIL reset_tag_req: got req=%h write=%h, expected req=001 write=0", tag_req, tag_write);
    end
    tick();
    rst = 1'b0;
    check_sweep(SIZE);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || tag_req.we !== 1'b0) begin
      n_fail++;
      $display("FAIL first_ready: got ready=%0b we=%0b at cycle %0d, expected ready=1 we=0", req_ready, tag_req.we, SIZE);
    end
    tick();
  endtask

  task automatic test_read_miss_hit;
    int n_mem;
    mem_log.delete();
    run_txn(32'h0000_1230, 1'b0, 0);
    n_checks++;
    if (mem_log.size() != 1 || mem_log[0] !== {1'b0, 32'h0000_1230}) begin
      n_fail++;
      $display("FAIL read_miss_refill: got %0d reqs first=%h, expected 1 req 0_00001230", mem_log.size(), mem_log[0]);
    end
    check_last_write(10'h123, {1'b1, 1'b0, 18'h0}, "read_miss_tag");
    issue(32'h0000_1230, 1'b0, n_mem);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hit_n1: got rv=%0b hit=%0b mv=%0b, expected 1 1 0", resp_valid, resp_hit, mem_req_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_hit_n2_ready: got %0b, expected 1", req_ready);
    end
    tick();
  endtask

  task automatic test_store_hit;
    int n_mem;
    issue(32'h0000_1234, 1'b1, n_mem);
    @(negedge clk);
    n_checks++;
    if (tag_req.we !== 1'b1 || tag_req.index !== 10'h123 || tag_write !== {1'b1, 1'b1, 18'h0} || resp_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL store_hit_write: got we=%0b index=%h data=%h hit=%0b, expected we=1 index=123 data=c0000 hit=1",
               tag_req.we, tag_req.index, tag_write, resp_hit);
    end
    tick();
    issue(32'h0000_1238, 1'b1, n_mem);
    @(negedge clk);
    n_checks++;
    if (tag_req.we !== 1'b0) begin
      n_fail++;
      $display("FAIL store_hit_dirty_nowrite: got we=%0b, expected 0", tag_req.we);
    end
    tick();
  endtask

  task automatic test_dirty_conflict;
    mem_log.delete();
    run_txn(32'h0040_1230, 1'b0, 0);
    n_checks++;
    if (mem_log.size() != 2 || mem_log[0] !== {1'b1, 32'h0000_1230} || mem_log[1] !== {1'b0, 32'h0040_1230}) begin
      n_fail++;
      $display("FAIL dirty_conflict_order: got %0d reqs %h %h, expected 1_00001230 0_00401230",
               mem_log.size(), mem_log[0], mem_log[1]);
    end
    check_last_write(10'h123, {1'b1, 1'b0, 18'h100}, "dirty_conflict_tag");
  endtask

  task automatic test_backpressure;
    run_txn(32'h0040_1230, 1'b1, 0);
    mem_log.delete();
    run_txn(32'h0000_1230, 1'b0, 5);
    n_checks++;
    if (mem_log.size() != 2 || mem_log[0] !== {1'b1, 32'h0040_1230} || mem_log[1] !== {1'b0, 32'h0000_1230}) begin
      n_fail++;
      $display("FAIL backpressure_handshakes: got %0d reqs %h %h, expected 1_00401230 0_00001230",
               mem_log.size(), mem_log[0], mem_log[1]);
    end
  endtask

  task automatic test_mid_refill_reset;
    int n_mem, k;
    issue(32'h0080_1230, 1'b0, n_mem);
    serve_mem(0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 || tag_req !== {10'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got mv=%0b rv=%0b ready=%0b req=%h, expected 0 0 0 001",
               mem_req_valid, resp_valid, req_ready, tag_req);
    end
    exp_resp_q.delete();
    exp_mem_q.delete();
    model_clear();
    tick();
    rst = 1'b0;
    check_sweep(4);
    k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < SIZE + 10) begin
      tick();
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (req_ready !== 1'b1 || k != SIZE - 4) begin
      n_fail++;
      $display("FAIL mid_reset_sweep_len: got ready=%0b after %0d more cycles, expected ready=1 after %0d",
               req_ready, k, SIZE - 4);
    end
    tick();
    mem_log.delete();
    run_txn(32'h0000_1230, 1'b0, 0);
    n_checks++;
    if (mem_log.size() != 1 || mem_log[0] !== {1'b0, 32'h0000_1230}) begin
      n_fail++;
      $display("FAIL post_reset_miss: got %0d reqs first=%h, expected 1 req 0_00001230", mem_log.size(), mem_log[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      a = {14'(($urandom_range(0, 2)) << 4), 4'h0, 10'($urandom_range(16, 19)), 4'($urandom_range(0, 15))};
      run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_store_hit();
    test_dirty_conflict();
    test_backpressure();
    test_back_to_back();
    test_mid_refill_reset();
    n_checks++;
    if (exp_mem_q.size() != 0 || exp_resp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d mem and %0d resp expectations pending, expected 0 0",
               exp_mem_q.size(), exp_resp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Direct-mapped cache tag controller: the initiator that drives the tag memory port (`tag_req`, `tag_write`, `tag_read`). It accepts CPU lookups, compares against the stored tag, issues victim write-back and line refill requests to the memory side on a miss, and updates valid/dirty/tag state. After reset it sweeps every tag entry to invalid before accepting requests.

## Interface

Parameters:
- `size`, 1024: number of tag entries; must equal the attached tag memory depth.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_addr`  in  32  byte address: tag = [31:14], index = [13:4], offset = [3:0].
- `req_we`  in  1  request is a store.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_hit`  out  1  completion was a hit; valid only with `resp_valid`.
- `mem_req_valid`  out  1  memory-side request.
- `mem_req_ready`  in  1  memory side accepts the request.
- `mem_req_wb`  out  1  1 = victim write-back, 0 = refill.
- `mem_req_addr`  out  32  line address; [3:0] = 0.
- `mem_resp_valid`  in  1  one-cycle pulse: the outstanding memory operation is done.
- `tag_req`  out  `cache::cache_req_t`  {index, we} to the tag memory.
- `tag_write`  out  `cache::cache_tag_t`  {valid, dirty, tag} write data.
- `tag_read`  in  `cache::cache_tag_t`  combinational read of `tag_req.index`.

## Operation

- States: INIT, IDLE, COMPARE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, UPDATE.
- **INIT:**
  - Drive `tag_req.we=1`, `tag_req.index=cnt`, `tag_write='0`; `cnt` increments each cycle.
  - At `cnt==size-1`, go to IDLE.
  - `req_ready=0`.
- **IDLE:**
  - `req_ready=1`.
  - When `req_valid`, latch `r_addr` and `r_we`, then go to COMPARE.
- **COMPARE:**
  - `tag_req.index=r_addr[13:4]`.
  - Hit = `tag_read.valid && tag_read.tag==r_addr[31:14]`.
  - On a hit:
    - Pulse `resp_valid` with `resp_hit=1`.
    - If `r_we && !tag_read.dirty`, write `{1,1,tag}` in the same cycle.
    - Go to IDLE.
  - On a miss:
    - Latch the victim tag.
    - Go to WB_REQ if victim valid && dirty, else RF_REQ.
- **WB_REQ:**
  - `mem_req_valid=1`, `mem_req_wb=1`, `mem_req_addr={victim_tag, index, 4'h0}`.
  - On `mem_req_ready`, go to WB_WAIT.
- **WB_WAIT:** on `mem_resp_valid`, go to RF_REQ.
- **RF_REQ:**
  - `mem_req_valid=1`, `mem_req_wb=0`, `mem_req_addr={r_addr[31:4], 4'h0}`.
  - On `mem_req_ready`, go to RF_WAIT.
- **RF_WAIT:** on `mem_resp_valid`, go to UPDATE.
- **UPDATE:**
  - Write `{valid=1, dirty=r_we, tag=r_addr[31:14]}`.
  - Pulse `resp_valid` with `resp_hit=0`.
  - Go to IDLE.
- `tag_req.we=0` in every state/cycle not listed as writing.
- `mem_resp_valid` outside the WAIT states is ignored.
- `req_valid` outside IDLE is ignored; requests are not queued.

## Timing

- **Reset values:**
  - state = INIT, `cnt=0`.
  - `req_ready=0`, `resp_valid=0`, `resp_hit=0`.
  - `mem_req_valid=0`, `mem_req_wb=0`, `mem_req_addr=0`.
  - `tag_req={index 0, we 1}`, `tag_write='0`.
  - The INIT write to index 0 during reset is intended.
- First `req_ready=1` is `size` cycles after reset deassertion (1024 cycles by default).
- **Hit:** request accepted at cycle N; `resp_valid` at N+1; `req_ready` again at N+2.
- **Clean miss:**
  - `mem_req_valid` from N+2 until the cycle `mem_req_ready` is high.
  - UPDATE is the cycle after `mem_resp_valid`.
- **Dirty miss:** write-back handshake completes fully (`mem_resp_valid`) before the refill request is issued.
- `mem_req_*` outputs must be stable while `mem_req_valid && !mem_req_ready`.
- `mem_req_ready` and `mem_resp_valid` high in the same cycle as the request: the response is not counted. `mem_resp_valid` is only sampled from the following WAIT state.
- **Reset mid-operation:**
  - Outstanding memory transaction is abandoned; `mem_req_valid` drops immediately.
  - INIT sweep restarts from index 0.
- `cnt` is `$clog2(size)` bits; the `size-1` compare ends the sweep with no wrap.

## Structure

- `cache_req_t`, `cache_tag_t`, and the TAG/INDEX/OFFSET width constants (18/10/4) live in package `cache`.
- The FSM state enum is local to this module.
- No sub-module is required.
- Bench pairs the block with `tag_memory_cache_sim` and a behavioural memory responder.

## Test plan

- **Reset sweep:** release `rst` → `tag_req.we` high for 1024 consecutive cycles, indices 0..1023; `req_ready` first at cycle 1024.
- **Read miss, then hit:** read at `0x0000_1230` → refill `mem_req_addr=0x0000_1230`, `wb=0`; index 0x123 written `{1,0,0}`; `resp_hit=0`. Same read again → `resp_valid` at N+1, `resp_hit=1`, no memory request.
- **Store hit:** store to `0x0000_1234` → index 0x123 written `{1,1,0}`; `resp_hit=1`.
- **Dirty conflict:** read at `0x0040_1230` →
  - write-back `0x0000_1230` with `wb=1`;
  - then refill `0x0040_1230`;
  - tag becomes `{1,0,0x100}`.
- **Backpressure:** `mem_req_ready` held low 5 cycles → `mem_req_valid`/`addr` stable throughout; single handshake.
- **Mid-refill reset:** assert `rst` in RF_WAIT → `mem_req_valid=0`, `resp_valid=0`, sweep restarts at index 0.
